// File: rtl/sched_edge_checker.sv
// Full-rate monitor for a divided-clock capture scheme: checks that two derived clocks rise
// together at the expected period and that their captured values agree.
module sched_edge_checker #(
  parameter int unsigned EXP_PERIOD  = 2,
  parameter int unsigned NUM_CYC     = 100,
  parameter int unsigned ARM_TIMEOUT = 16,
  parameter int unsigned MAX_ERR     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        div_a,
  input  logic        div_b,
  input  logic        cap_a,
  input  logic        cap_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] edge_count,
  output logic [15:0] first_err_cyc
);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StDone, StFail} state_e;

  localparam logic [15:0] LastCyc   = 16'(NUM_CYC - 1);
  localparam logic [7:0]  ArmLast   = 8'(ARM_TIMEOUT - 1);
  localparam logic [8:0]  ExpPeriod = 9'(EXP_PERIOD);
  localparam logic [7:0]  MaxErr    = 8'(MAX_ERR);

  state_e      state_q, state_d;
  logic        prev_a_q, prev_b_q;
  logic [7:0]  err_q, err_d;
  logic [15:0] edge_q, edge_d;
  logic [15:0] first_q, first_d;
  logic [15:0] cyc_q, cyc_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  arm_q, arm_d;

  logic       rise_a, rise_b;
  logic       edge_err, data_err, period_err;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [7:0] err_sat;

  always_comb begin
    rise_a     = div_a & ~prev_a_q;
    rise_b     = div_b & ~prev_b_q;
    edge_err   = rise_a != rise_b;
    // Case inequality so an X/Z capture is flagged rather than masked.
    data_err   = cap_a !== cap_b;
    period_err = rise_a && (({1'b0, gap_q} + 9'd1) != ExpPeriod);
    err_inc    = {1'b0, edge_err} + {1'b0, data_err} + {1'b0, period_err};
    err_sum    = {1'b0, err_q} + {7'd0, err_inc};
    err_sat    = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    edge_d  = edge_q;
    first_d = first_q;
    cyc_d   = cyc_q;
    gap_d   = gap_q;
    arm_d   = arm_q;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d = StArm;
          err_d   = 8'd0;
          edge_d  = 16'd0;
          first_d = 16'hFFFF;
          cyc_d   = 16'd0;
          gap_d   = 8'd0;
          arm_d   = 8'd0;
        end
      end
      StArm: begin
        if (rise_a) begin
          // This rise is the period reference only; it is not counted or checked.
          state_d = StRun;
          cyc_d   = 16'd0;
          gap_d   = 8'd0;
        end else if (arm_q == ArmLast) begin
          state_d = StFail;
          err_d   = 8'd1;
        end else begin
          arm_d = arm_q + 8'd1;
        end
      end
      StRun: begin
        err_d = err_sat;
        if (err_q == 8'd0 && err_inc != 2'd0) begin
          first_d = cyc_q;
        end
        if (rise_a) begin
          gap_d = 8'd0;
          if (edge_q != 16'hFFFF) edge_d = edge_q + 16'd1;
        end else if (gap_q != 8'hFF) begin
          gap_d = gap_q + 8'd1;
        end
        if (err_sat >= MaxErr) begin
          state_d = StFail;
        end else if (cyc_q == LastCyc) begin
          state_d = StDone;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
      err_q    <= 8'd0;
      edge_q   <= 16'd0;
      first_q  <= 16'hFFFF;
      cyc_q    <= 16'd0;
      gap_q    <= 8'd0;
      arm_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      prev_a_q <= div_a;
      prev_b_q <= div_b;
      err_q    <= err_d;
      edge_q   <= edge_d;
      first_q  <= first_d;
      cyc_q    <= cyc_d;
      gap_q    <= gap_d;
      arm_q    <= arm_d;
    end
  end

  always_comb begin
    busy          = (state_q == StArm) || (state_q == StRun);
    done          = (state_q == StDone) || (state_q == StFail);
    pass          = (state_q == StDone) && (err_q == 8'd0);
    err_count     = err_q;
    edge_count    = edge_q;
    first_err_cyc = first_q;
  end

endmodule
